// File: rtl/spi_slave.sv
// spi_slave: SPI responder with sysio register port, 8-bit MSB-first frames in all four CPOL/CPHA modes.
module spi_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  input  logic        spi_clk_i,
  input  logic        spi_cs_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso,
  output logic        spi_miso_oe
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q;
  // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detection
  logic [2:0] cs_q, sclk_q;
  logic [1:0] mosi_q;
  logic en_q, cpol_q, cpha_q, txf_q, rxv_q, ovr_q, miso_q;
  logic [7:0] tx_q, rx_q, sh_q, rsh_q;
  logic [3:0] bit_cnt_q;
  logic [31:0] data_q;
  logic wr_ctrl, wr_tx, wr_stat, rd_rx, cs_fall, cs_rise, lead, trail, samp, shft;
  logic start, leave, done, reload;
  logic [7:0] tx_d;
  logic [31:0] rdata_d;
  logic unused;
  assign unused = &{1'b0, waddr_i[7:4], raddr_i[7:4], data_i[31:8], sel_i[3:1]};
  always_comb begin
    wr_ctrl = we_i && waddr_i[3:0] == 4'h0 && sel_i[0];
    wr_tx = we_i && waddr_i[3:0] == 4'h4;
    wr_stat = we_i && waddr_i[3:0] == 4'hC;
    rd_rx = rd_i && raddr_i[3:0] == 4'h8;
    cs_fall = cs_q[2] & ~cs_q[1];
    cs_rise = ~cs_q[2] & cs_q[1];
    lead = (sclk_q[1] ^ sclk_q[2]) & (sclk_q[1] ^ cpol_q);
    trail = (sclk_q[1] ^ sclk_q[2]) & ~(sclk_q[1] ^ cpol_q);
    samp = cpha_q ? trail : lead;
    // in CPHA=0 the trailing edge after the 8th sample must not shift the freshly reloaded byte
    shft = cpha_q ? lead : trail & (bit_cnt_q != 4'd0);
    start = state_q == IDLE && en_q && cs_fall;
    leave = state_q == ACTIVE && (cs_rise || !en_q);
    done = state_q == ACTIVE && bit_cnt_q == 4'd8 && !leave;
    reload = start | done;
    tx_d = wr_tx ? data_i[7:0] : txf_q ? tx_q : 8'h00;
    rdata_d = raddr_i[3:0] == 4'h0 ? {29'd0, cpha_q, cpol_q, en_q}
            : raddr_i[3:0] == 4'h4 ? {24'd0, tx_q}
            : raddr_i[3:0] == 4'h8 ? {24'd0, rx_q}
            : raddr_i[3:0] == 4'hC ? {28'd0, ovr_q, txf_q, rxv_q, state_q == ACTIVE}
            : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cs_q <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      {en_q, cpol_q, cpha_q, txf_q, rxv_q, ovr_q, miso_q} <= 7'd0;
      {tx_q, rx_q, sh_q, rsh_q} <= 32'd0;
      bit_cnt_q <= 4'd0;
      data_q <= 32'd0;
    end else begin
      cs_q <= {cs_q[1:0], spi_cs_i};
      sclk_q <= {sclk_q[1:0], spi_clk_i};
      mosi_q <= {mosi_q[0], spi_mosi_i};
      if (wr_ctrl) {cpha_q, cpol_q, en_q} <= data_i[2:0];
      if (wr_tx) tx_q <= data_i[7:0];
      txf_q <= !reload && (wr_tx || txf_q);
      rxv_q <= done || (rxv_q && !rd_rx);
      ovr_q <= (done && rxv_q && !rd_rx) || (ovr_q && !(wr_stat && data_i[3]));
      if (rd_i) data_q <= rdata_d;
      if (done) rx_q <= rsh_q;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          bit_cnt_q <= 4'd0;
          if (start) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (leave) begin
            state_q <= IDLE;
            miso_q <= 1'b0;
            bit_cnt_q <= 4'd0;
          end else if (done) begin
            bit_cnt_q <= 4'd0;
          end else begin
            if (samp) begin
              rsh_q <= {rsh_q[6:0], mosi_q[1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (shft) begin
              miso_q <= sh_q[7];
              sh_q <= {sh_q[6:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (reload && cpha_q) sh_q <= tx_d;
      if (reload && !cpha_q) begin
        miso_q <= tx_d[7];
        sh_q <= {tx_d[6:0], 1'b0};
      end
    end
  end
  assign data_o = data_q;
  assign spi_miso = miso_q;
  assign spi_miso_oe = en_q & ~cs_q[1];
endmodule
